contador_bcd_ctrl: RTL and testbench
====================================

Name: contador_bcd_ctrl

Overview:
Run-control and display controller for the 3-digit BCD counter used on the board.
- Turns debounced start/stop/clear buttons into a start/pause/clear FSM.
- Generates the counting tick from a prescaler and steps a 000–999 BCD value up or down.
- Time-multiplexes the three digits onto one digit bus with active-low anode enables for the 7-segment decoder.

Parameters:
- PRESC_N, 26, width of prescaler counter.
- PRESC_MAX, 49_999_999, prescaler terminal value; tick period = PRESC_MAX+1 clk cycles.
- SCAN_N, 17, width of display scan counter.
- SCAN_MAX, 99_999, scan terminal value; digit dwell = SCAN_MAX+1 clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- btn_start  in  1  debounced, synchronized level
- btn_stop  in  1  debounced, synchronized level
- btn_clear  in  1  debounced, synchronized level
- up_dn  in  1  1 = count up, 0 = count down
- running  out  1  1 while FSM in RUN
- tick_out  out  1  one-cycle pulse on each count step
- overflow  out  1  one-cycle pulse on wrap (or saturation)
- bcd2, bcd1, bcd0  out  4 each  hundreds/tens/units digits
- digit  out  4  BCD digit currently displayed
- an  out  3  active-low anode enables, one-hot-low

Behaviour:
- Reset (reset=0 at rising clk):
  - state=IDLE; bcd2/1/0=0; prescaler=0; scan counter=0; digit index=0.
  - an=3'b110; digit=0; running=0; tick_out=0; overflow=0.
  - Button history regs set to 1, so a button held through reset does not fire.
  - Reset mid-count overrides everything in the same cycle.
- Edge detect: p_x = btn_x & ~btn_x_q, where btn_x_q is the previous sample.
  - One pulse per press; a held button never repeats.
- Pulse priority in one cycle: clear > stop > start.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: digits 000, prescaler held at 0. p_start → RUN.
  - RUN: prescaler counts. p_stop → PAUSE. p_clear → IDLE.
  - PAUSE: prescaler and digits hold their values. p_start → RUN (resumes mid-period). p_clear → IDLE.
  - p_clear in any state: next cycle IDLE, digits 000, prescaler 0.
- State change timing: the state updates on the first rising clk where the button is sampled 1 after 0. running is registered and follows the state.
- Prescaler (RUN only, no stop/clear pulse that cycle):
  - At PRESC_MAX it wraps to 0, and tick_out=1 for the next cycle.
  - The digits update on the same edge that raises tick_out.
  - A stop or clear pulse in the terminal cycle wins: no step, no tick.
- BCD arithmetic, per step:
  - Up: units 9→0 carries into tens; 999→000 with overflow=1 for one cycle.
  - Down: units 0→9 borrows from tens; 000→999 with overflow=1.
  - Digits never leave 0–9.
  - up_dn is sampled at each step; changing it mid-period only affects the next step.
- Display scan (always runs, independent of FSM):
  - Scan counter counts 0..SCAN_MAX and wraps.
  - On each wrap the digit index advances 0→1→2→0.
  - an: index0=3'b110, index1=3'b101, index2=3'b011.
  - digit = bcd0/bcd1/bcd2 for index 0/1/2; registered, changes on the same edge as an.
- All outputs are registered.

Optional Feature:
SATURATE_EN
- Defined: counting stops at the limit instead of wrapping.
  - Up step at 999, or down step at 000: digits unchanged, overflow=1 for one cycle, FSM → PAUSE (running drops on the same edge).
  - p_start in PAUSE at the limit re-enters RUN. The next step in the same direction saturates again.
  - Changing up_dn lets counting move away from the limit.
- Not defined: wrap-around as in Behaviour; FSM never leaves RUN because of a wrap.

Test Plan (PRESC_MAX=3, SCAN_MAX=1, so a tick every 4 cycles and 2-cycle digit dwell):
1. Hold reset=0 with btn_start=1, then release reset keeping btn_start=1 → state stays IDLE, running=0, an=110, digits 000. Drop then raise btn_start → running=1 next cycle, first tick_out 4 cycles later, bcd0=1.
2. RUN up from 000 for 10 ticks → 010. Continue to 999; next tick → 000 with overflow=1 for exactly one cycle, coincident with tick_out. Then SATURATE_EN build → stays 999, overflow pulse, running=0.
3. up_dn=0 at 000, start → first tick gives 999 with overflow=1. Next tick gives 998. At 100 → 099 (tens and hundreds borrow).
4. RUN at 042 with prescaler=2, press stop → PAUSE holds 042 and prescaler=2 for 20 cycles. Press start → tick after 2 cycles gives 043.
5. Same cycle: btn_clear and btn_stop rise while prescaler=PRESC_MAX in RUN → no tick_out, next state IDLE, digits 000. Separately, clear in PAUSE → IDLE.
6. Digits 321, observe 12 cycles → an sequence 110,110,101,101,011,011 repeating; digit sequence 1,1,2,2,3,3. Scan continues unchanged across start/stop/clear.

Source files
------------

// File: rtl/contador_bcd_ctrl.sv
// contador_bcd_ctrl: run-control FSM, prescaled 000-999 BCD up/down counter
// and 3-digit multiplexed display driver.
// Optional build macro SATURATE_EN: counting stops at 999/000 and the FSM
// drops to PAUSE instead of wrapping.
module contador_bcd_ctrl #(
  parameter int PRESC_N   = 26,
  parameter int PRESC_MAX = 49_999_999,
  parameter int SCAN_N    = 17,
  parameter int SCAN_MAX  = 99_999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       up_dn,
  output logic       running,
  output logic       tick_out,
  output logic       overflow,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [3:0] digit,
  output logic [2:0] an
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [PRESC_N-1:0] PRESC_TERM = PRESC_N'(PRESC_MAX);
  localparam logic [SCAN_N-1:0]  SCAN_TERM  = SCAN_N'(SCAN_MAX);

  state_t              state, state_nxt;
  logic                btn_start_q, btn_stop_q, btn_clear_q;
  logic                p_start, p_stop, p_clear;
  logic [PRESC_N-1:0]  presc;
  logic [SCAN_N-1:0]   scan;
  logic [1:0]          idx, idx_nxt;
  logic                step;
  logic [12:0]         stepped;

  // One BCD increment/decrement; bit 12 flags wrap past 999 or below 000.
  function automatic logic [12:0] bcd_step(input logic [11:0] v, input logic up);
    logic [3:0] d0, d1, d2;
    logic       c;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    c  = 1'b1;
    if (up) begin
      if (d0 == 4'd9) d0 = 4'd0; else begin d0 = d0 + 4'd1; c = 1'b0; end
      if (c) begin
        if (d1 == 4'd9) d1 = 4'd0; else begin d1 = d1 + 4'd1; c = 1'b0; end
      end
      if (c) begin
        if (d2 == 4'd9) d2 = 4'd0; else begin d2 = d2 + 4'd1; c = 1'b0; end
      end
    end else begin
      if (d0 == 4'd0) d0 = 4'd9; else begin d0 = d0 - 4'd1; c = 1'b0; end
      if (c) begin
        if (d1 == 4'd0) d1 = 4'd9; else begin d1 = d1 - 4'd1; c = 1'b0; end
      end
      if (c) begin
        if (d2 == 4'd0) d2 = 4'd9; else begin d2 = d2 - 4'd1; c = 1'b0; end
      end
    end
    return {c, d2, d1, d0};
  endfunction

  // Active-low anode pattern for a digit index.
  function automatic logic [2:0] anode_of(input logic [1:0] i);
    case (i)
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  assign p_start = btn_start & ~btn_start_q;
  assign p_stop  = btn_stop  & ~btn_stop_q;
  assign p_clear = btn_clear & ~btn_clear_q;

  // A count step happens only in the terminal prescaler cycle of RUN,
  // and a stop or clear pulse in that cycle suppresses it.
  assign step    = (state == RUN) && (presc == PRESC_TERM) && !p_clear && !p_stop;
  assign stepped = bcd_step({bcd2, bcd1, bcd0}, up_dn);

  // Next-state logic with clear > stop > start priority.
  always_comb begin
    state_nxt = state;
    if (p_clear) begin
      state_nxt = IDLE;
    end else if (p_stop) begin
      if (state == RUN) state_nxt = PAUSE;
    end else if (p_start) begin
      if (state != RUN) state_nxt = RUN;
    end
`ifdef SATURATE_EN
    if (step && stepped[12]) state_nxt = PAUSE;
`endif
  end

  // State register; running is registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  // Button history, preset to 1 so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_start_q <= 1'b1;
      btn_stop_q  <= 1'b1;
      btn_clear_q <= 1'b1;
    end else begin
      btn_start_q <= btn_start;
      btn_stop_q  <= btn_stop;
      btn_clear_q <= btn_clear;
    end
  end

  // Prescaler, BCD digits and the tick/overflow pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc    <= '0;
      bcd2     <= 4'd0;
      bcd1     <= 4'd0;
      bcd0     <= 4'd0;
      tick_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      overflow <= 1'b0;
      if (p_clear || (state == IDLE)) begin
        presc <= '0;
        bcd2  <= 4'd0;
        bcd1  <= 4'd0;
        bcd0  <= 4'd0;
      end else if ((state == RUN) && !p_stop) begin
        if (step) begin
          presc    <= '0;
          tick_out <= 1'b1;
          overflow <= stepped[12];
`ifdef SATURATE_EN
          if (!stepped[12]) {bcd2, bcd1, bcd0} <= stepped[11:0];
`else
          {bcd2, bcd1, bcd0} <= stepped[11:0];
`endif
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Next digit index: advances once per scan-counter wrap.
  always_comb begin
    idx_nxt = idx;
    if (scan == SCAN_TERM) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  // Free-running display scan; anode and digit change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan  <= '0;
      idx   <= 2'd0;
      an    <= 3'b110;
      digit <= 4'd0;
    end else begin
      scan  <= (scan == SCAN_TERM) ? '0 : scan + 1'b1;
      idx   <= idx_nxt;
      an    <= anode_of(idx_nxt);
      case (idx_nxt)
        2'd1:    digit <= bcd1;
        2'd2:    digit <= bcd2;
        default: digit <= bcd0;
      endcase
    end
  end

endmodule

// File: tb/tb_contador_bcd_ctrl.sv
// Testbench for contador_bcd_ctrl with a small prescaler and scan period.
module tb_contador_bcd_ctrl;

  localparam int PM = 3;
  localparam int SM = 1;

  logic       clk = 1'b0;
  logic       reset, btn_start, btn_stop, btn_clear, up_dn;
  logic       running, tick_out, overflow;
  logic [3:0] bcd2, bcd1, bcd0, digit;
  logic [2:0] an;

  contador_bcd_ctrl #(.PRESC_N(4), .PRESC_MAX(PM), .SCAN_N(2), .SCAN_MAX(SM)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_clear(btn_clear), .up_dn(up_dn), .running(running), .tick_out(tick_out),
    .overflow(overflow), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .digit(digit), .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: value held as a plain integer 0..999, mode as 0/1/2.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_st, m_cnt, m_presc, m_n;
  bit m_tick, m_ovf, m_run;
  int m_digit;
  bit m_pv_start, m_pv_stop, m_pv_clear;

  function automatic int digit_of(input int v, input int i);
    if (i == 0) return v % 10;
    if (i == 1) return (v / 10) % 10;
    return v / 100;
  endfunction

  function automatic int anode_exp(input int i);
    if (i == 0) return 3'b110;
    if (i == 1) return 3'b101;
    return 3'b011;
  endfunction

  always @(posedge clk) begin : model
    bit ps, pt, pc;
    if (!reset) begin
      m_st = M_IDLE; m_cnt = 0; m_presc = 0; m_n = 0;
      m_tick = 0; m_ovf = 0; m_run = 0; m_digit = 0;
      m_pv_start = 1; m_pv_stop = 1; m_pv_clear = 1;
    end else begin
      ps = btn_start && !m_pv_start;
      pt = btn_stop  && !m_pv_stop;
      pc = btn_clear && !m_pv_clear;
      m_digit = digit_of(m_cnt, ((m_n + 1) / (SM + 1)) % 3);
      m_n++;
      m_tick = 0;
      m_ovf  = 0;
      if (pc) begin
        m_st = M_IDLE; m_cnt = 0; m_presc = 0;
      end else if (pt) begin
        if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (m_st == M_RUN) begin
        if (m_presc == PM) begin
          m_presc = 0;
          m_tick  = 1;
          if ((up_dn && m_cnt == 999) || (!up_dn && m_cnt == 0)) begin
            m_ovf = 1;
`ifdef SATURATE_EN
            m_st = M_PAUSE;
`else
            m_cnt = up_dn ? 0 : 999;
`endif
          end else begin
            m_cnt = up_dn ? m_cnt + 1 : m_cnt - 1;
          end
        end else begin
          m_presc++;
        end
      end else if (ps) begin
        m_st = M_RUN;
      end
      m_run = (m_st == M_RUN);
      m_pv_start = btn_start; m_pv_stop = btn_stop; m_pv_clear = btn_clear;
    end
  end

  task automatic check_all();
    chk("running",  running,  m_run);
    chk("tick_out", tick_out, m_tick);
    chk("overflow", overflow, m_ovf);
    chk("bcd", {bcd2, bcd1, bcd0},
        ((m_cnt / 100) << 8) | (((m_cnt / 10) % 10) << 4) | (m_cnt % 10));
    chk("an",    an,    anode_exp((m_n / (SM + 1)) % 3));
    chk("digit", digit, m_digit);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    reset = 1'b0; btn_start = 1'b1; btn_stop = 1'b0; btn_clear = 1'b0; up_dn = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    // Start held through reset must not fire.
    reset = 1'b1;
    cyc(6);
    btn_start = 1'b0;
    cyc(1);
    btn_start = 1'b1;
    // Count up through 999 -> 000.
    cyc(4 * 1005 + 10);
    // Stop/pause hold, then resume.
    btn_stop = 1'b1; cyc(20);
    btn_stop = 1'b0; btn_start = 1'b0; cyc(2);
    btn_start = 1'b1; cyc(12);
    // Clear and stop together in the terminal prescaler cycle.
    for (int i = 0; i < 8 && !(m_st == M_RUN && m_presc == PM); i++) cyc(1);
    chk("terminal_reached", (m_st == M_RUN && m_presc == PM), 1);
    btn_clear = 1'b1; btn_stop = 1'b1; cyc(3);
    btn_clear = 1'b0; btn_stop = 1'b0; btn_start = 1'b0; cyc(2);
    // Count down from 000 through 999 and past 900.
    up_dn = 1'b0;
    btn_start = 1'b1; cyc(4 * 160);
    // Clear from PAUSE.
    btn_stop = 1'b1; cyc(3);
    btn_clear = 1'b1; cyc(3);
    btn_clear = 1'b0; btn_stop = 1'b0; btn_start = 1'b0; cyc(2);
    // Randomized phase.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(7) == 0)   btn_start = ~btn_start;
      if ($urandom_range(15) == 0)  btn_stop  = ~btn_stop;
      if ($urandom_range(31) == 0)  btn_clear = ~btn_clear;
      if ($urandom_range(63) == 0)  up_dn     = ~up_dn;
      reset = ($urandom_range(499) != 0);
      cyc(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
